// File: rtl/buffer_byte_streamer.sv
// buffer_byte_streamer: streams a byte range out of a 16-bit word RAM over a valid/ready port.
// Define BUFFER_STREAMER_PREFETCH_EN to fetch the next word during EMIT for bubble-free output.
module buffer_byte_streamer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [10:0] StartAddr,
  input  logic [10:0] Length,
  input  logic        Abort,
  output logic        Busy,
  output logic        Done,
  output logic        RamReadEnable,
  output logic [9:0]  RamReadAddr,
  input  logic [15:0] RamReadData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [7:0]  OutData,
  output logic        OutLast
);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} state_t;
  state_t state, state_nx;
  logic [10:0] ptr;
  logic [11:0] cnt;
  logic [15:0] word, cur, word_adv;
  logic cur_pend, xfer, last, adv, rd_pf;
  // RAM data arrives one cycle after the read, so the first EMIT cycle reads it straight off the bus
  assign cur = cur_pend ? RamReadData : word;
  assign xfer = state == EMIT && OutReady;
  assign last = cnt == 12'd1;
  assign adv = xfer && ptr[0] && !last;
`ifdef BUFFER_STREAMER_PREFETCH_EN
  localparam bit pf = 1'b1;
  logic [15:0] nxt;
  logic nxt_valid, nxt_pend;
  assign rd_pf = state == EMIT && cnt > (ptr[0] ? 12'd1 : 12'd2) && !nxt_valid && !nxt_pend;
  assign word_adv = nxt_valid ? nxt : RamReadData;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      nxt <= '0;
      nxt_valid <= 1'b0;
      nxt_pend <= 1'b0;
    end else if (Abort || state != EMIT) begin
      nxt_valid <= 1'b0;
      nxt_pend <= 1'b0;
    end else begin
      nxt <= nxt_pend ? RamReadData : nxt;
      nxt_valid <= !adv && (nxt_valid || nxt_pend);
      nxt_pend <= rd_pf && !adv;
    end
`else
  localparam bit pf = 1'b0;
  assign rd_pf = 1'b0;
  assign word_adv = RamReadData;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Start ? FETCH : IDLE;
      FETCH:   state_nx = EMIT;
      EMIT:    state_nx = !xfer ? EMIT : last ? FINISH : (ptr[0] && !pf) ? FETCH : EMIT;
      default: state_nx = IDLE;
    endcase
    if (Abort) state_nx = IDLE;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (state == IDLE && Start && !Abort) begin
      ptr <= StartAddr;
      cnt <= {Length == 11'd0, Length};
    end else if (xfer && !Abort) begin
      ptr <= ptr + 11'd1;
      cnt <= cnt - 12'd1;
    end
  // a word boundary crossed with prefetch either takes the held word or the read issued this cycle
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      word <= '0;
      cur_pend <= 1'b0;
    end else if (Abort) cur_pend <= 1'b0;
    else if (state == FETCH) cur_pend <= 1'b1;
    else if (pf && adv) begin
      word <= word_adv;
      cur_pend <= rd_pf;
    end else if (cur_pend) begin
      word <= RamReadData;
      cur_pend <= 1'b0;
    end
  assign Busy = state == FETCH || state == EMIT;
  assign Done = state == FINISH;
  assign OutValid = state == EMIT;
  assign OutData = state != EMIT ? 8'd0 : ptr[0] ? cur[15:8] : cur[7:0];
  assign OutLast = state == EMIT && last;
  assign RamReadEnable = state == FETCH || rd_pf;
  assign RamReadAddr = state == FETCH ? ptr[10:1] : rd_pf ? ptr[10:1] + 10'd1 : 10'd0;
endmodule

// File: tb/tb_buffer_byte_streamer.sv
// tb_buffer_byte_streamer: directed checks of buffer_byte_streamer against a synchronous RAM model.
module tb_buffer_byte_streamer;
  logic clk = 1'b0, rst, start, abort, busy, done, ren, out_valid, out_ready, out_last;
  logic [10:0] start_addr, length;
  logic [9:0] raddr;
  logic [15:0] rdata;
  logic [7:0] out_data;
  logic [15:0] mem [0:1023];
  int n_assert = 0, n_fail = 0, cyc = 0, s_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [7:0] byte_q[$];
  logic last_q[$];
  int cyc_q[$];
  logic [9:0] addr_q[$];
  logic stalled = 1'b0;
  logic [8:0] prev_out = '0;
`ifdef BUFFER_STREAMER_PREFETCH_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 2;
`endif

  buffer_byte_streamer dut (
    .Clk(clk), .Reset(rst), .Start(start), .StartAddr(start_addr), .Length(length),
    .Abort(abort), .Busy(busy), .Done(done), .RamReadEnable(ren), .RamReadAddr(raddr),
    .RamReadData(rdata), .OutValid(out_valid), .OutReady(out_ready), .OutData(out_data),
    .OutLast(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ren) rdata <= mem[raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start && !busy && !rst) s_cyc = cyc + 1;
    if (ren) addr_q.push_back(raddr);
    if (out_valid && out_ready && !abort && !rst) begin
      byte_q.push_back(out_data);
      last_q.push_back(out_last);
      cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (stalled && out_valid) check("stall_hold", {23'd0, out_last, out_data}, {23'd0, prev_out});
    stalled = out_valid && !out_ready && !abort;
    prev_out = {out_last, out_data};
  end

  task automatic start_xfer(input logic [10:0] a, input logic [10:0] l);
    byte_q.delete(); last_q.delete(); cyc_q.delete(); addr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_idle"}, {31'd0, busy}, 0);
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [31:0] eb, input logic [3:0] el);
    logic [31:0] ab = '0;
    logic [3:0] al = '0;
    check({tag, "_count"}, byte_q.size(), n);
    for (int i = 0; i < n && i < byte_q.size(); i++) begin
      ab[i*8 +: 8] = byte_q[i];
      al[i] = last_q[i];
    end
    check({tag, "_bytes"}, ab, eb);
    check({tag, "_last"}, {28'd0, al}, {28'd0, el});
  endtask

  initial begin
    int n, mism, lasts;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start_addr = '0; length = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #3;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_last", {31'd0, out_last}, 0);
    check("rst_data", {24'd0, out_data}, 0);
    check("rst_ren", {31'd0, ren}, 0);
    check("rst_raddr", {22'd0, raddr}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    mem[0] = 16'h2211; mem[1] = 16'h4433;
    start_xfer(11'd0, 11'd4);
    wait_done("basic", 40);
    check_bytes("basic", 4, 32'h44332211, 4'b1000);
    check("basic_first_latency", cyc_q[0] - s_cyc, 1);
    check("basic_gap_in_word", cyc_q[1] - cyc_q[0], 1);
    check("basic_gap_word_edge", cyc_q[2] - cyc_q[1], GAP);
    check("basic_done_after_last", done_cyc - cyc_q[3], 1);
    check("basic_reads", addr_q.size(), 2);

    mem[1] = 16'hBBAA; mem[2] = 16'hDDCC;
    start_xfer(11'd3, 11'd2);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 11'd100;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("odd", 40);
    check_bytes("odd", 2, 32'h0000CCBB, 4'b0010);
    check("odd_reads", addr_q.size(), 2);
    check("odd_addrs", {addr_q[0], addr_q[1]}, {10'd1, 10'd2});

    mem[1023] = 16'h9988; mem[0] = 16'h7766;
    start_xfer(11'd2047, 11'd2);
    wait_done("wrap", 40);
    check_bytes("wrap", 2, 32'h00006699, 4'b0010);
    check("wrap_addrs", {addr_q[0], addr_q[1]}, {10'd1023, 10'd0});

    for (int i = 0; i < 1024; i++) mem[i] = {i[7:0] ^ 8'h5A, i[7:0]};
    start_xfer(11'd0, 11'd0);
    wait_done("full", 5000);
    check("full_count", byte_q.size(), 2048);
    mism = 0; lasts = 0;
    for (int k = 0; k < byte_q.size(); k++) begin
      logic [9:0] w;
      w = 10'(k >> 1);
      if (byte_q[k] !== (k[0] ? (w[7:0] ^ 8'h5A) : w[7:0])) mism++;
      if (last_q[k]) lasts++;
    end
    check("full_data_mismatches", mism, 0);
    check("full_last_count", lasts, 1);
    check("full_last_pos", {31'd0, last_q[2047]}, 1);

    mem[0] = 16'h2211; mem[1] = 16'h4433;
    start_xfer(11'd0, 11'd4);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("stall", 40);
    check_bytes("stall", 4, 32'h44332211, 4'b1000);

    start_xfer(11'd0, 11'd4);
    n = 0;
    while (byte_q.size() < 3 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach3", byte_q.size(), 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_valid", {31'd0, out_valid}, 0);
    check("abort_done", {31'd0, done}, 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_bytes", byte_q.size(), 3);
    check("abort_no_done", done_cnt, 0);

    start_xfer(11'd0, 11'd4);
    wait_done("after_abort", 40);
    check_bytes("after_abort", 4, 32'h44332211, 4'b1000);

    start_xfer(11'd0, 11'd4);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("reset_no_done", done_cnt, 0);

    start_xfer(11'd0, 11'd4);
    wait_done("after_reset", 40);
    check_bytes("after_reset", 4, 32'h44332211, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/buffer_byte_streamer.md
BUFFER_BYTE_STREAMER -- requirements
Module: buffer_byte_streamer

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock, all logic on posedge.
REQ-002 SHALL have ports: Reset  in  1  asynchronous, active-high.
REQ-003 SHALL have ports: Start  in  1  begin transfer, sampled only when Busy=0.
REQ-004 SHALL have ports: StartAddr  in  11  byte address of first byte.
REQ-005 SHALL have ports: Length  in  11  byte count; 0 means 2048.
REQ-006 SHALL have ports: Abort  in  1  terminate transfer.
REQ-007 SHALL have ports: Busy  out  1  transfer in progress.
REQ-008 SHALL have ports: Done  out  1  one-cycle pulse on normal completion.
REQ-009 SHALL have ports: RamReadEnable  out  1  read strobe to 16-bit RAM read port.
REQ-010 SHALL have ports: RamReadAddr  out  10  word address.
REQ-011 SHALL have ports: RamReadData  in  16  word data, valid in the cycle after RamReadEnable; byte 2n in [7:0], byte 2n+1 in [15:8].
REQ-012 SHALL have ports: OutValid  out  1; OutReady  in  1; OutData  out  8; OutLast  out  1 (final byte).

Function
REQ-013 SHALL implement states IDLE, FETCH, EMIT, FINISH.
REQ-014 IDLE: Start=1 latches StartAddr and Length, sets Busy=1, goes to FETCH; Start while Busy=1 SHALL be ignored.
REQ-015 FETCH: RamReadEnable=1 for one cycle with RamReadAddr=byte pointer[10:1], OutValid=0; next edge captures RamReadData into word register, goes to EMIT.
REQ-016 EMIT: OutValid=1; OutData = word[7:0] if pointer[0]=0 else word[15:8]; a byte is transferred on an edge with OutValid=1 and OutReady=1.
REQ-017 SHALL hold OutData/OutLast stable while OutValid=1 and OutReady=0.
REQ-018 Each transfer SHALL increment the 11-bit byte pointer modulo 2048 (2047 wraps to 0) and decrement the remaining count.
REQ-019 Odd StartAddr SHALL emit the high byte of the first word first, then fetch the next word.
REQ-020 OutLast SHALL equal 1 exactly when remaining count = 1.
REQ-021 Transfer of the last byte SHALL go to FINISH: Done=1 one cycle, Busy=0, then IDLE.
REQ-022 Transfer of a word's high byte (not last) SHALL go to FETCH (without prefetch, see REQ-027).
REQ-023 Abort=1 in any state SHALL return to IDLE at the next edge with OutValid=0, Busy=0, Done=0; Abort has priority over Start and over a concurrent byte transfer (that byte counts as not sent).
REQ-024 First OutValid SHALL appear in the second cycle after the edge sampling Start.

Reset
REQ-025 Reset=1 SHALL asynchronously force state IDLE, Busy=0, Done=0, OutValid=0, OutLast=0, OutData=0, RamReadEnable=0, RamReadAddr=0, pointer and count 0.
REQ-026 Reset mid-transfer SHALL discard the transfer; no Done pulse after release.

Configuration
REQ-027 Macro BUFFER_STREAMER_PREFETCH_EN defined: during EMIT the next word SHALL be read into a second register while the current word's bytes are emitted, so with OutReady held 1 bytes transfer every cycle with no bubble across word boundaries; no read beyond the last needed word.
REQ-028 Macro undefined: no prefetch register; one OutValid=0 cycle (FETCH) between words.

Verification
REQ-029 StartAddr=0, Length=4, RAM words 0x2211,0x4433, OutReady=1 -> bytes 11,22,33,44; OutLast on 44; Done one cycle later; with prefetch 4 consecutive valid cycles, without 1 bubble after 22.
REQ-030 StartAddr=3, Length=2, word1=0xBBAA, word2=0xDDCC -> bytes BB, CC; OutLast on CC.
REQ-031 StartAddr=2047, Length=2, word1023=0x9988, word0=0x7766 -> bytes 99, 66; RamReadAddr 1023 then 0.
REQ-032 Length=0 -> exactly 2048 bytes, OutLast only on the 2048th, one Done.
REQ-033 OutReady toggled 1,0,0,1 during transfer -> OutData stable while stalled, no byte lost or duplicated.
REQ-034 Abort after 3rd byte, Reset pulse in a second transfer -> Busy=0, OutValid=0 next cycle / immediately; no Done; new Start accepted afterwards.
